rx_frontend_mc: RTL and testbench

Parametrised multi-channel receive front end of the OFDM modem. Converts offset-binary ADC samples to two's complement, removes DC, mixes the fs/4 IF to baseband I/Q and decimates by integrate-and-dump on the 40 MHz domain. Output is a valid-strobed baseband stream for the channel filter and normaliser chain. Per-channel ADC overload monitoring is included. NUM_CH=1 reproduces today's single-ADC path with a strobe instead of a derived clock.

---
 rtl/rx_pkg.sv | 32 +++
 rtl/rx_dc_block.sv | 58 +++++
 rtl/rx_frontend_mc.sv | 113 +++++++++++
 tb/tb_rx_frontend_mc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and helpers for the multi-channel receive front end.
package rx_pkg;

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } phase_e;

    function automatic int sum_width(input int in_w, input int decim);
        return in_w + $clog2(decim);
    endfunction

    localparam int SUM_W = sum_width(14, 4);

    // Clamp a signed value to the w-bit two's complement range.
    function automatic logic signed [31:0] sat_w(input logic signed [31:0] v, input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int unsigned w);
        return sat_w(-v, w);
    endfunction

endpackage

// File: rtl/rx_dc_block.sv
// One channel: offset-binary capture, DC-removal high-pass and overload monitor.
module rx_dc_block
    import rx_pkg::*;
#(
    parameter int IN_W      = 14,
    parameter int DC_SHIFT  = 10,
    parameter int OVR_CNT_W = 16
) (
    input  logic                 clk_40,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_W-1:0]      adc_data,
    input  logic                 adc_ovr,
    input  logic                 ovr_clr,
    output logic [IN_W-1:0]      d_out,
    output logic                 ovr_flag,
    output logic [OVR_CNT_W-1:0] ovr_count
);
    localparam int ACC_W = IN_W + DC_SHIFT + 1;

    logic signed [IN_W-1:0]  x_r;
    logic                    ovr_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W:0]   d_raw;
    logic signed [IN_W-1:0]  d_sat;
    logic                    ovr_hit;

    assign d_raw   = (ACC_W+1)'(x_r) - (ACC_W+1)'(acc_r >>> DC_SHIFT);
    assign d_sat   = IN_W'(sat_w(32'(d_raw), IN_W));
    assign ovr_hit = en & ovr_r;

    always_ff @(posedge clk_40) begin
        if (rst) begin
            x_r       <= '0;
            ovr_r     <= 1'b0;
            acc_r     <= '0;
            d_out     <= '0;
            ovr_flag  <= 1'b0;
            ovr_count <= '0;
        end else begin
            if (en) begin
                x_r   <= {~adc_data[IN_W-1], adc_data[IN_W-2:0]};
                ovr_r <= adc_ovr;
                acc_r <= acc_r + ACC_W'(d_sat);
                d_out <= d_sat;
            end
            // A clear that coincides with a counted overload leaves that overload recorded.
            if (ovr_clr) begin
                ovr_flag  <= ovr_hit;
                ovr_count <= {{(OVR_CNT_W-1){1'b0}}, ovr_hit};
            end else if (ovr_hit) begin
                ovr_flag <= 1'b1;
                if (ovr_count != '1) ovr_count <= ovr_count + OVR_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rx_frontend_mc.sv
// Multi-channel receive front end: DC block, fs/4 mix to baseband, integrate-and-dump decimation.
module rx_frontend_mc
    import rx_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int IN_W      = 14,
    parameter int OUT_W     = 16,
    parameter int DECIM     = 4,
    parameter int DC_SHIFT  = 10,
    parameter int OVR_CNT_W = 16
) (
    input  logic                        clk_40,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_CH*IN_W-1:0]      adc_data,
    input  logic [NUM_CH-1:0]           adc_ovr,
    input  logic                        ovr_clr,
    output logic                        out_valid,
    output logic [NUM_CH*OUT_W-1:0]     out_i,
    output logic [NUM_CH*OUT_W-1:0]     out_q,
    output logic [NUM_CH-1:0]           ovr_flag,
    output logic [NUM_CH*OVR_CNT_W-1:0] ovr_count
);
    localparam int SUM_WC = sum_width(IN_W, DECIM);
    localparam int CNT_W  = $clog2(DECIM);

    phase_e           phase_r;
    phase_e           mix_ph;
    logic [CNT_W-1:0] cnt_r;
    logic             wrap;

    // phase_r tags the sample entering capture; the mixer sees it two enabled samples later.
    assign mix_ph = phase_e'(phase_r + 2'd2);
    assign wrap   = (cnt_r == CNT_W'(DECIM - 1));

    always_ff @(posedge clk_40) begin
        if (rst) begin
            phase_r   <= PH_0;
            cnt_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en & wrap;
            if (en) begin
                phase_r <= phase_e'(phase_r + 2'd1);
                cnt_r   <= wrap ? '0 : cnt_r + CNT_W'(1);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [IN_W-1:0]          d_u;
        logic signed [IN_W-1:0]   d;
        logic signed [IN_W-1:0]   mix_i;
        logic signed [IN_W-1:0]   mix_q;
        logic signed [SUM_WC-1:0] sum_i;
        logic signed [SUM_WC-1:0] sum_q;
        logic signed [OUT_W-1:0]  oi_r;
        logic signed [OUT_W-1:0]  oq_r;

        rx_dc_block #(
            .IN_W      (IN_W),
            .DC_SHIFT  (DC_SHIFT),
            .OVR_CNT_W (OVR_CNT_W)
        ) u_dc (
            .clk_40    (clk_40),
            .rst       (rst),
            .en        (en),
            .adc_data  (adc_data[c*IN_W +: IN_W]),
            .adc_ovr   (adc_ovr[c]),
            .ovr_clr   (ovr_clr),
            .d_out     (d_u),
            .ovr_flag  (ovr_flag[c]),
            .ovr_count (ovr_count[c*OVR_CNT_W +: OVR_CNT_W])
        );

        assign d = $signed(d_u);

        always_comb begin
            mix_i = '0;
            mix_q = '0;
            case (mix_ph)
                PH_0:    mix_i = d;
                PH_1:    mix_q = IN_W'(sat_neg(32'(d), IN_W));
                PH_2:    mix_i = IN_W'(sat_neg(32'(d), IN_W));
                PH_3:    mix_q = d;
                default: ;
            endcase
        end

        always_ff @(posedge clk_40) begin
            if (rst) begin
                sum_i <= '0;
                sum_q <= '0;
                oi_r  <= '0;
                oq_r  <= '0;
            end else if (en) begin
                if (wrap) begin
                    oi_r  <= OUT_W'(sum_i);
                    oq_r  <= OUT_W'(sum_q);
                    sum_i <= SUM_WC'(mix_i);
                    sum_q <= SUM_WC'(mix_q);
                end else begin
                    sum_i <= sum_i + SUM_WC'(mix_i);
                    sum_q <= sum_q + SUM_WC'(mix_q);
                end
            end
        end

        assign out_i[c*OUT_W +: OUT_W] = oi_r;
        assign out_q[c*OUT_W +: OUT_W] = oq_r;
    end

endmodule

// File: tb/tb_rx_frontend_mc.sv
// Directed self-checking bench for rx_frontend_mc (2 channels, DECIM=4, 8-bit overload counters).
module tb_rx_frontend_mc;
    localparam int NUM_CH    = 2;
    localparam int IN_W      = 14;
    localparam int OUT_W     = 16;
    localparam int DECIM     = 4;
    localparam int DC_SHIFT  = 10;
    localparam int OVR_CNT_W = 8;

    logic                        clk_40 = 1'b0;
    logic                        rst;
    logic                        en;
    logic [NUM_CH*IN_W-1:0]      adc_data;
    logic [NUM_CH-1:0]           adc_ovr;
    logic                        ovr_clr;
    logic                        out_valid;
    logic [NUM_CH*OUT_W-1:0]     out_i;
    logic [NUM_CH*OUT_W-1:0]     out_q;
    logic [NUM_CH-1:0]           ovr_flag;
    logic [NUM_CH*OVR_CNT_W-1:0] ovr_count;

    int checks = 0;
    int errors = 0;
    int n_en   = 0;

    logic [IN_W-1:0] seq  [12];
    logic [IN_W-1:0] tone [4];

    rx_frontend_mc #(
        .NUM_CH    (NUM_CH),
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .DECIM     (DECIM),
        .DC_SHIFT  (DC_SHIFT),
        .OVR_CNT_W (OVR_CNT_W)
    ) dut (
        .clk_40    (clk_40),
        .rst       (rst),
        .en        (en),
        .adc_data  (adc_data),
        .adc_ovr   (adc_ovr),
        .ovr_clr   (ovr_clr),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q),
        .ovr_flag  (ovr_flag),
        .ovr_count (ovr_count)
    );

    always #12 clk_40 = ~clk_40;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_40);
        if (rst) n_en = 0;
        else if (en) n_en++;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] get_i(input int c);
        return out_i[c*OUT_W +: OUT_W];
    endfunction

    function automatic logic [15:0] get_q(input int c);
        return out_q[c*OUT_W +: OUT_W];
    endfunction

    function automatic int sabs(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        ovr_clr  = 1'b0;
        adc_ovr  = '0;
        adc_data = {14'h2000, 14'h2000};
        tick();
        rst = 1'b0;
    endtask

    // ch0 gets the directed sequence, ch1 a steady mid-scale (zero) input.
    task automatic run_seq(input int gap_at);
        for (int j = 0; j < 12; j++) begin
            adc_data = {14'h2000, seq[j]};
            en       = 1'b1;
            tick();
            chk("seq_valid", 64'(out_valid), 64'((j % 4) == 3));
            if (j == 3) begin
                chk("seq_b0_i0", 64'(get_i(0)), 64'h0000);
                chk("seq_b0_q0", 64'(get_q(0)), 64'h0000);
            end
            if (j == 7) begin
                chk("seq_b1_i0", 64'(get_i(0)), 64'h2007);
                chk("seq_b1_q0", 64'(get_q(0)), 64'h0008);
                chk("seq_b1_i1", 64'(get_i(1)), 64'h0000);
            end
            if (j == 11) begin
                chk("seq_b2_i0", 64'(get_i(0)), 64'h0000);
                chk("seq_b2_q0", 64'(get_q(0)), 64'hE001);
                chk("seq_b2_q1", 64'(get_q(1)), 64'h0000);
            end
            if (j == gap_at) begin
                for (int g = 0; g < 5; g++) begin
                    en       = 1'b0;
                    adc_data = {14'h0000, 14'h0000};
                    tick();
                    chk("gap_valid", 64'(out_valid), 64'h0);
                    chk("gap_hold_i0", 64'(get_i(0)), 64'h2007);
                end
            end
        end
    endtask

    initial begin
        seq = '{14'h2000, 14'h2000, 14'h0000, 14'h2000, 14'h2000, 14'h3FFF,
                14'h2000, 14'h2000, 14'h2000, 14'h2000, 14'h2000, 14'h2000};
        tone = '{14'h3000, 14'h2000, 14'h1000, 14'h2000};

        // Reset state
        do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_out_i", 64'(out_i), 64'h0);
        chk("rst_out_q", 64'(out_q), 64'h0);
        chk("rst_flag", 64'(ovr_flag), 64'h0);
        chk("rst_count", 64'(ovr_count), 64'h0);

        // Impulse as the last sample of the first block after reset
        do_reset();
        adc_data = {14'h0000, 14'h3FFF};
        en       = 1'b1;
        tick();
        adc_data = {14'h2000, 14'h2000};
        for (int j = 1; j < 5; j++) begin
            tick();
            chk("imp_valid", 64'(out_valid), 64'(j == 3));
            if (j == 3) begin
                chk("imp_i0", 64'(get_i(0)), 64'h1FFF);
                chk("imp_i1", 64'(get_i(1)), 64'hE000);
                chk("imp_q0", 64'(get_q(0)), 64'h0000);
                chk("imp_q1", 64'(get_q(1)), 64'h0000);
            end
        end

        // Saturating negation and DC-block arithmetic, then the same with an en gap
        do_reset();
        run_seq(-1);
        do_reset();
        run_seq(8);

        // fs/4 tone on both channels
        do_reset();
        for (int j = 0; j < 256; j++) begin
            adc_data = {tone[j % 4], tone[j % 4]};
            en       = 1'b1;
            tick();
            chk("tone_valid", 64'(out_valid), 64'((j % 4) == 3));
        end
        for (int c = 0; c < NUM_CH; c++) begin
            chk("tone_i", 64'(sabs(get_i(c) - 16'd8192) <= 16), 64'h1);
            chk("tone_q", 64'(sabs(get_q(c)) <= 16), 64'h1);
        end

        // Overload monitor
        adc_ovr = 2'b10;
        repeat (3) tick();
        adc_ovr = 2'b00;
        repeat (2) tick();
        chk("ovr_flag3", 64'(ovr_flag), 64'h2);
        chk("ovr_cnt1_3", 64'(ovr_count[15:8]), 64'h3);
        chk("ovr_cnt0_3", 64'(ovr_count[7:0]), 64'h0);
        adc_ovr = 2'b10;
        tick();
        adc_ovr = 2'b00;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("clr_flag", 64'(ovr_flag), 64'h2);
        chk("clr_cnt1", 64'(ovr_count[15:8]), 64'h1);
        tick();
        chk("clr_cnt1_hold", 64'(ovr_count[15:8]), 64'h1);
        adc_ovr = 2'b11;
        repeat (261) tick();
        adc_ovr = 2'b00;
        repeat (2) tick();
        chk("sat_cnt0", 64'(ovr_count[7:0]), 64'hFF);
        chk("sat_cnt1", 64'(ovr_count[15:8]), 64'hFF);
        chk("sat_flag", 64'(ovr_flag), 64'h3);

        // Reset mid-block at decimation count 2
        for (int k = 0; k < 8 && (n_en % 4) != 2; k++) begin
            adc_data = {tone[k % 4], tone[k % 4]};
            tick();
        end
        chk("pre_rst_cnt", 64'(n_en % 4), 64'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_out_i", 64'(out_i), 64'h0);
        chk("mid_rst_out_q", 64'(out_q), 64'h0);
        chk("mid_rst_flag", 64'(ovr_flag), 64'h0);
        chk("mid_rst_count", 64'(ovr_count), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("mid_rst_strobe", 64'(out_valid), 64'(k == 4));
        end

        // DC rejection after 8 time constants
        do_reset();
        for (int j = 0; j < 8192; j++) begin
            adc_data = {14'h3000, 14'h3000};
            en       = 1'b1;
            tick();
        end
        chk("dc_valid", 64'(out_valid), 64'h1);
        for (int c = 0; c < NUM_CH; c++) begin
            chk("dc_i", 64'(sabs(get_i(c)) < 16 * DECIM), 64'h1);
            chk("dc_q", 64'(sabs(get_q(c)) < 16 * DECIM), 64'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
